// File: rtl/div_share_arbiter.sv
// div_share_arbiter: one RV32M divider shared by two cores, round-robin granted, with early-out for div-by-zero and overflow.
module div_share_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [1:0]  req0_sel,
  input  logic        flush0,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_rd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [1:0]  req1_sel,
  input  logic        flush1,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_rd,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rs1_q, rs2_q, res_q;
  logic [1:0]  sel_q;
  logic        owner_q, last_q;
  logic        elig0, elig1, gnt0, gnt1, own_flush, own_ready, special, ovf;
  logic [31:0] rs1_d, rs2_d, res_d, quo_s, rem_s;
  logic [1:0]  sel_d;
  // last_q==1 means core 1 won last, so core 0 has priority on contention
  assign elig0 = req0_valid && !flush0;
  assign elig1 = req1_valid && !flush1;
  assign gnt0 = elig0 && (!elig1 || last_q);
  assign gnt1 = elig1 && (!elig0 || !last_q);
  assign req0_ready = state_q == IDLE && gnt0;
  assign req1_ready = state_q == IDLE && gnt1;
  assign rs1_d = gnt1 ? req1_rs1 : req0_rs1;
  assign rs2_d = gnt1 ? req1_rs2 : req0_rs2;
  assign sel_d = gnt1 ? req1_sel : req0_sel;
  assign special = rs2_d == '0 || (rs1_d == 32'h8000_0000 && rs2_d == '1 && !sel_d[0]);
  assign own_flush = owner_q ? flush1 : flush0;
  assign own_ready = owner_q ? resp1_ready : resp0_ready;
  assign quo_s = $signed(rs1_q) / $signed(rs2_q);
  assign rem_s = $signed(rs1_q) % $signed(rs2_q);
  assign ovf = rs1_q == 32'h8000_0000 && rs2_q == '1;
  assign res_d = rs2_q == '0 ? (sel_q[1] ? rs1_q : '1)
               : ovf && !sel_q[0] ? (sel_q[1] ? '0 : 32'h8000_0000)
               : sel_q == 2'b00 ? quo_s
               : sel_q == 2'b01 ? rs1_q / rs2_q
               : sel_q == 2'b10 ? rem_s
               : rs1_q % rs2_q;
  assign resp0_valid = state_q == RESP && !owner_q;
  assign resp1_valid = state_q == RESP && owner_q;
  assign resp0_rd = res_q;
  assign resp1_rd = res_q;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      sel_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (gnt0 || gnt1) begin
          state_q <= BUSY;
          owner_q <= gnt1;
          last_q  <= gnt1;
          rs1_q   <= rs1_d;
          rs2_q   <= rs2_d;
          sel_q   <= sel_d;
          cnt_q   <= special ? 4'd0 : 4'(LATENCY - 1);
        end
        BUSY: if (own_flush) state_q <= IDLE;
          else if (cnt_q == 4'd0) begin
            res_q   <= res_d;
            state_q <= RESP;
          end else cnt_q <= cnt_q - 4'd1;
        RESP: if (own_flush || own_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: vector table plus hand sequences for arbitration, backpressure, flush and reset.
module tb_div_share_arbiter;
  localparam int LAT = 4;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, flush0 = 0, flush1 = 0, resp0_ready = 0, resp1_ready = 0;
  logic [31:0] req0_rs1 = 0, req0_rs2 = 0, req1_rs1 = 0, req1_rs2 = 0;
  logic [1:0] req0_sel = 0, req1_sel = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [31:0] resp0_rd, resp1_rd;
  int checks = 0, failures = 0;
  typedef struct packed {logic core; logic [31:0] rd;} exp_t;
  typedef struct packed {logic core; logic [31:0] a; logic [31:0] b; logic [1:0] sel; logic [31:0] exp; logic early;} vec_t;
  exp_t sb[$];
  vec_t vecs[15];
  div_share_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req0_sel(req0_sel), .flush0(flush0), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_rd(resp0_rd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req1_sel(req1_sel), .flush1(flush1), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_rd(resp1_rd),
    .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic rdy(input logic c);
    return c ? req1_ready : req0_ready;
  endfunction
  function automatic logic respv(input logic c);
    return c ? resp1_valid : resp0_valid;
  endfunction
  task automatic drive(input logic c, input logic [31:0] a, input logic [31:0] b, input logic [1:0] s, input logic v);
    if (c) begin req1_rs1 = a; req1_rs2 = b; req1_sel = s; req1_valid = v; end
    else begin req0_rs1 = a; req0_rs2 = b; req0_sel = s; req0_valid = v; end
  endtask
  // called at a falling edge; returns at the falling edge right after acceptance
  task automatic present(input logic c, input logic [31:0] a, input logic [31:0] b, input logic [1:0] s, input logic [31:0] e);
    int n = 0;
    drive(c, a, b, s, 1'b1);
    #1;
    while (!rdy(c) && n < 20) begin @(negedge clk); #1; n++; end
    chk("req_ready", {31'b0, rdy(c)}, 1);
    sb.push_back('{c, e});
    @(negedge clk);
    drive(c, a, b, s, 1'b0);
  endtask
  task automatic finish_op(input logic c, input logic early);
    exp_t x;
    int k = 0;
    while (!respv(c) && k < 40) begin
      if (respv(!c)) chk("wrong_core_valid", 1, 0);
      @(negedge clk);
      k++;
    end
    chk("latency", k, early ? 1 : LAT);
    chk("busy_in_resp", {31'b0, busy}, 1);
    chk("other_valid", {31'b0, respv(!c)}, 0);
    if (c) resp1_ready = 1; else resp0_ready = 1;
    if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      x = sb.pop_front();
      chk("resp_core", {31'b0, c}, {31'b0, x.core});
      chk("resp_rd", c ? resp1_rd : resp0_rd, x.rd);
    end
    @(negedge clk);
    resp0_ready = 0;
    resp1_ready = 0;
    chk("idle_after_consume", {31'b0, busy}, 0);
  endtask
  initial begin
    logic exp_g[3];
    bit seen;
    int n;
    vecs = '{
      '{1'b0, 32'hFFFFFFF9, 32'h2,        2'b00, 32'hFFFFFFFD, 1'b0},
      '{1'b0, 32'hFFFFFFF9, 32'h2,        2'b10, 32'hFFFFFFFF, 1'b0},
      '{1'b1, 32'h5,        32'h0,        2'b01, 32'hFFFFFFFF, 1'b1},
      '{1'b1, 32'h1234,     32'h0,        2'b11, 32'h1234,     1'b1},
      '{1'b0, 32'h80000000, 32'hFFFFFFFF, 2'b00, 32'h80000000, 1'b1},
      '{1'b1, 32'h80000000, 32'hFFFFFFFF, 2'b10, 32'h0,        1'b1},
      '{1'b0, 32'h80000000, 32'hFFFFFFFF, 2'b01, 32'h0,        1'b0},
      '{1'b1, 32'h80000000, 32'hFFFFFFFF, 2'b11, 32'h80000000, 1'b0},
      '{1'b1, 32'h64,       32'hFFFFFFF9, 2'b00, 32'hFFFFFFF2, 1'b0},
      '{1'b1, 32'h64,       32'hFFFFFFF9, 2'b10, 32'h2,        1'b0},
      '{1'b0, 32'hFFFFFF9C, 32'h7,        2'b10, 32'hFFFFFFFE, 1'b0},
      '{1'b1, 32'hFFFFFFFF, 32'hA,        2'b01, 32'h19999999, 1'b0},
      '{1'b0, 32'h0,        32'h0,        2'b00, 32'hFFFFFFFF, 1'b1},
      '{1'b0, 32'h3E8,      32'h7,        2'b11, 32'h6,        1'b0},
      '{1'b1, 32'hFFFFFFF9, 32'h0,        2'b10, 32'hFFFFFFF9, 1'b1}
    };
    #2;
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_valid", {30'b0, resp1_valid, resp0_valid}, 0);
    chk("reset_rd", resp0_rd, 0);
    // both cores contend from reset: core0, core1, core0
    @(negedge clk);
    rst = 0;
    resp0_ready = 1;
    resp1_ready = 1;
    drive(0, 32'd10, 32'd2, 2'b01, 1);
    drive(1, 32'd9, 32'd3, 2'b01, 1);
    exp_g = '{1'b0, 1'b1, 1'b0};
    for (int g = 0; g < 3; g++) begin
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 40) begin @(negedge clk); #1; n++; end
      chk("rr_grant_core1", {31'b0, req1_ready}, {31'b0, exp_g[g]});
      chk("rr_grant_core0", {31'b0, req0_ready}, {31'b0, !exp_g[g]});
      @(negedge clk);
    end
    req0_valid = 0;
    req1_valid = 0;
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk("rr_drain", {31'b0, busy}, 0);
    resp0_ready = 0;
    resp1_ready = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      present(vecs[i].core, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp);
      finish_op(vecs[i].core, vecs[i].early);
    end
    // backpressure: core0 result held while core1 waits
    @(negedge clk);
    present(0, 32'hFFFFFFF9, 32'h2, 2'b00, 32'hFFFFFFFD);
    drive(1, 32'd20, 32'd4, 2'b01, 1);
    n = 0;
    while (!resp0_valid && n < 40) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'b0, resp0_valid}, 1);
      chk("bp_rd", resp0_rd, 32'hFFFFFFFD);
      chk("bp_req1_ready", {31'b0, req1_ready}, 0);
      chk("bp_busy", {31'b0, busy}, 1);
      @(negedge clk);
    end
    resp0_ready = 1;
    if (sb.size() != 0) chk("bp_rd_consumed", resp0_rd, sb.pop_front().rd);
    @(negedge clk);
    resp0_ready = 0;
    chk("bp_resp_gone", {31'b0, resp0_valid}, 0);
    present(1, 32'd20, 32'd4, 2'b01, 32'd5);
    finish_op(1, 0);
    // owner flush in the second BUSY cycle, then core1 accepted at once
    @(negedge clk);
    present(0, 32'd100, 32'd3, 2'b01, 32'd33);
    drive(1, 32'd100, 32'd3, 2'b01, 1);
    @(negedge clk);
    flush0 = 1;
    @(negedge clk);
    flush0 = 0;
    void'(sb.pop_back());
    chk("flush_busy", {31'b0, busy}, 0);
    chk("flush_no_resp", {31'b0, resp0_valid}, 0);
    #1;
    chk("flush_then_accept", {31'b0, req1_ready}, 1);
    present(1, 32'd100, 32'd3, 2'b01, 32'd33);
    flush0 = 1;
    finish_op(1, 0);
    flush0 = 0;
    // reset in the middle of BUSY
    @(negedge clk);
    drive(0, 32'd100, 32'd7, 2'b01, 1);
    #1;
    chk("rst_pre_accept", {31'b0, req0_ready}, 1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_busy_now", {31'b0, busy}, 0);
    chk("rst_valid_now", {31'b0, resp0_valid}, 0);
    chk("rst_rd_now", resp0_rd, 0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      seen |= resp0_valid | busy;
      @(negedge clk);
    end
    chk("rst_no_resp", {31'b0, seen}, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    drive(1, 32'd1000, 32'd7, 2'b01, 1);
    #1;
    chk("accept_after_rst", {31'b0, req1_ready}, 1);
    sb.push_back('{1'b1, 32'd142});
    @(negedge clk);
    req1_valid = 0;
    finish_op(1, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_share_arbiter.md
DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set the number of BUSY cycles for a normal divide (legal range 1..15).
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Ports reqN_valid, input, 1 (N=0,1): core N presents a divide op.
REQ-005 Ports reqN_ready, output, 1: the op from core N is accepted this cycle.
REQ-006 Ports reqN_rs1 and reqN_rs2, input, 32: dividend and divisor.
REQ-007 Ports reqN_sel, input, 2: operation select; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 Ports flushN, input, 1: cancels any op belonging to core N.
REQ-009 Ports respN_valid, output, 1: the result for core N is valid.
REQ-010 Ports respN_ready, input, 1: core N consumes the result.
REQ-011 Ports respN_rd, output, 32: the result value.
REQ-012 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-014 In IDLE, a request SHALL be eligible only when reqN_valid=1 and flushN=0.
REQ-015 In IDLE, reqN_ready SHALL be combinational and high for the granted eligible core only; it SHALL be 0 in all other states.
REQ-016 Arbitration SHALL be round-robin: with both cores eligible, grant the core not granted last; with one eligible, grant it.
REQ-017 The last_grant register SHALL update on acceptance.
REQ-018 On acceptance, rs1, rs2, sel and the owner ID SHALL be registered, and the FSM SHALL go to BUSY.
REQ-019 On entering BUSY, the counter SHALL load LATENCY-1 for normal ops.
REQ-020 On entering BUSY, the counter SHALL load 0 (early-out) for special cases: rs2==0 (any sel), or rs1==0x80000000 with rs2==0xFFFFFFFF for sel 00/10.
REQ-021 In BUSY, the counter SHALL decrement each cycle.
REQ-022 In BUSY with counter==0, the RV32M result SHALL be captured into the result register and the FSM SHALL go to RESP.
REQ-023 Result rules:
- Signed ops truncate toward zero.
- Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
- Overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
REQ-024 Latency: acceptance on edge C SHALL produce respN_valid from cycle C+LATENCY+1 for normal ops, and from C+2 for early-out ops.
REQ-025 In RESP, respN_valid SHALL be high for the owner only; respN_rd SHALL hold the result and stay stable until consumed.
REQ-026 In RESP, respN_valid and respN_ready both high for the owner SHALL return the FSM to IDLE.
REQ-027 A new request SHALL NOT be accepted in the same cycle a response is consumed.
REQ-028 Backpressure: RESP SHALL be held indefinitely while respN_ready=0.
REQ-029 Owner flush during BUSY or RESP SHALL discard the op: next state IDLE, no respN_valid pulse afterwards, last_grant unchanged.
REQ-030 Flush of the non-owner core SHALL have no effect on the op in flight.
REQ-031 Flush and respN_ready asserted in the same RESP cycle SHALL act as a flush (the response is treated as not delivered).
REQ-032 Outside RESP, respN_rd SHALL be don't-care; the implementation SHALL drive the result register.

Reset
REQ-033 On rst=1, regardless of clk, outputs SHALL clear immediately: state IDLE, counter 0, result register 0, respN_valid 0, busy 0.
REQ-034 On reset, last_grant SHALL be set to 1 so that core 0 wins the first contention.
REQ-035 Reset asserted mid-BUSY or mid-RESP SHALL abandon the op with no response, now or after release.
REQ-036 After rst deasserts, requests SHALL be accepted from the first rising edge.

Verification
REQ-037 Core0 DIV: rs1=0xFFFFFFF9, rs2=2, LATENCY=4 -> resp0_rd=0xFFFFFFFD at C+5; REM of the same operands -> 0xFFFFFFFF.
REQ-038 Core1 DIVU with rs2=0 -> resp1_rd=0xFFFFFFFF at C+2; REMU rs1=0x1234, rs2=0 -> 0x1234 at C+2.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0 (both early-out).
REQ-040 Both cores valid from reset with responses consumed immediately -> core0 served first, then core1, then core0 again while both stay valid.
REQ-041 Hold resp0_ready=0 for 10 cycles -> resp0_valid and resp0_rd stay stable, req1_ready stays 0, busy stays 1.
REQ-042 flush0 pulsed in the second BUSY cycle -> IDLE next cycle, no resp0_valid, and a pending core1 request is accepted on the following cycle; rst pulsed mid-BUSY -> busy=0 immediately, no response.
